board_input_conditioner: RTL and testbench

- Sits between the board pins (centre push-button, 16 slide switches) and the sigma SoC inputs `irq_btn_i` and `gpio_bi`.
- Synchronizes each raw input into the `clk_i` domain and debounces it with a shared sample-tick prescaler and a per-input stability counter.
- Provides clean levels, a one-cycle button rising-edge pulse, and a switch-change pulse with a change mask.
- Runs on the PLL-generated system clock, in the same domain as the SoC.

---
 rtl/board_input_conditioner.sv | 151 +++++++++++++++
 tb/tb_board_input_conditioner.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/board_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : board_input_conditioner
// Brief    : Synchronizes and debounces the board's centre push-button and
//            slide switches into the clk_i domain. All inputs share one
//            sample-tick prescaler; each input has its own stability counter.
//            Produces clean levels, a button rising-edge pulse and a
//            switch-change pulse with a per-bit change mask.
// Ports    : clk_i          system clock
//            rst_i          synchronous active-high reset
//            btn_i          raw push-button (asynchronous)
//            sw_i           raw slide switches (asynchronous)
//            btn_o          debounced button level
//            btn_rise_o     one-cycle pulse on debounced 0->1 of the button
//            sw_o           debounced switch levels
//            sw_chg_o       one-cycle pulse when any debounced switch changes
//            sw_chg_mask_o  old XOR new switch levels while sw_chg_o is 1
// Revision : 1.0 - initial release
// ============================================================================
module board_input_conditioner #(
    parameter int N_SW        = 16,
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_DIV  = 100000,
    parameter int STABLE_CNT  = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            btn_i,
    input  logic [N_SW-1:0] sw_i,
    output logic            btn_o,
    output logic            btn_rise_o,
    output logic [N_SW-1:0] sw_o,
    output logic            sw_chg_o,
    output logic [N_SW-1:0] sw_chg_mask_o
);

    // Bit 0 carries the button, bits N_SW:1 carry the switches.
    localparam int c_N_IN = N_SW + 1;
    localparam int c_PW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int c_CW   = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

    localparam logic [c_PW-1:0] c_PCNT_LAST = c_PW'(SAMPLE_DIV - 1);
    localparam logic [c_CW-1:0] c_CNT_LAST  = c_CW'(STABLE_CNT - 1);

    logic [c_N_IN-1:0] w_raw;
    logic [c_N_IN-1:0] r_sync [SYNC_STAGES];
    logic [c_N_IN-1:0] w_s;
    logic [c_PW-1:0]   r_pcnt;
    logic              w_tick;
    logic [c_N_IN-1:0] r_st;
    logic [c_N_IN-1:0] w_st_nxt;
    logic              r_rise;
    logic              r_chg;
    logic [N_SW-1:0]   r_mask;
    logic [N_SW-1:0]   w_sw_diff;

    assign w_raw = {sw_i, btn_i};

    // ------------------------------------------------------------------
    // Plain flop chain per input; nothing between stages.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= w_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Shared sample-tick prescaler. The tick coincides with the wrap, so
    // exactly one tick occurs per SAMPLE_DIV cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pcnt <= '0;
        end else if (r_pcnt == c_PCNT_LAST) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    assign w_tick = (r_pcnt == c_PCNT_LAST);

    // ------------------------------------------------------------------
    // Per-input stability counters. The counter holds the number of
    // consecutive ticks on which the synchronized input disagreed with the
    // accepted value; any agreeing sample restarts it, which is what
    // rejects bounce.
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < c_N_IN; k++) begin : g_deb
            logic [c_CW-1:0] r_cnt;
            logic            w_diff;
            logic            w_accept;

            assign w_diff   = w_s[k] ^ r_st[k];
            assign w_accept = w_tick & w_diff & (r_cnt == c_CNT_LAST);

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_cnt <= '0;
                end else if (w_tick) begin
                    if (!w_diff || w_accept) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_st_nxt[k] = w_accept ? w_s[k] : r_st[k];
        end
    endgenerate

    assign w_sw_diff = w_st_nxt[N_SW:1] ^ r_st[N_SW:1];

    // ------------------------------------------------------------------
    // Accepted values and event pulses share one register stage, so the
    // pulses line up with the first cycle the new level is visible.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_st   <= '0;
            r_rise <= 1'b0;
            r_chg  <= 1'b0;
            r_mask <= '0;
        end else begin
            r_st   <= w_st_nxt;
            r_rise <= w_st_nxt[0] & ~r_st[0];
            r_chg  <= |w_sw_diff;
            r_mask <= w_sw_diff;
        end
    end

    assign btn_o         = r_st[0];
    assign sw_o          = r_st[N_SW:1];
    assign btn_rise_o    = r_rise;
    assign sw_chg_o      = r_chg;
    assign sw_chg_mask_o = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_board_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_input_conditioner
// Brief    : Self-checking bench for board_input_conditioner. A behavioural
//            model (input delay line, cycle-count tick, consecutive-tick run
//            lengths) predicts every output each cycle; directed scenarios add
//            constant expectations for the key debounce cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_input_conditioner;

    localparam int N_SW        = 16;
    localparam int SYNC_STAGES = 2;
    localparam int SAMPLE_DIV  = 4;
    localparam int STABLE_CNT  = 3;
    localparam int c_N_IN      = N_SW + 1;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            btn_i;
    logic [N_SW-1:0] sw_i;
    logic            btn_o;
    logic            btn_rise_o;
    logic [N_SW-1:0] sw_o;
    logic            sw_chg_o;
    logic [N_SW-1:0] sw_chg_mask_o;

    int n_cmp = 0;
    int n_bad = 0;

    board_input_conditioner #(
        .N_SW        (N_SW),
        .SYNC_STAGES (SYNC_STAGES),
        .SAMPLE_DIV  (SAMPLE_DIV),
        .STABLE_CNT  (STABLE_CNT)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .btn_i         (btn_i),
        .sw_i          (sw_i),
        .btn_o         (btn_o),
        .btn_rise_o    (btn_rise_o),
        .sw_o          (sw_o),
        .sw_chg_o      (sw_chg_o),
        .sw_chg_mask_o (sw_chg_mask_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the raw inputs seen SYNC_STAGES edges ago, a tick
    // every SAMPLE_DIV-th cycle after reset, and a run length of
    // consecutive disagreeing ticks per input.
    // ------------------------------------------------------------------
    logic [c_N_IN-1:0] m_hist [SYNC_STAGES];
    int                m_k;
    int                m_run [c_N_IN];
    logic [c_N_IN-1:0] m_st;
    logic              m_rise;
    logic              m_chg;
    logic [N_SW-1:0]   m_mask;

    always @(posedge clk) begin
        logic [c_N_IN-1:0] s;
        logic [c_N_IN-1:0] old;
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = '0;
            for (int j = 0; j < c_N_IN; j++) m_run[j] = 0;
            m_k = 0; m_st = '0; m_rise = 0; m_chg = 0; m_mask = '0;
        end else begin
            s   = m_hist[SYNC_STAGES-1];
            old = m_st;
            if ((m_k % SAMPLE_DIV) == SAMPLE_DIV - 1) begin
                for (int j = 0; j < c_N_IN; j++) begin
                    if (s[j] != m_st[j]) begin
                        m_run[j]++;
                        if (m_run[j] == STABLE_CNT) begin
                            m_st[j]  = s[j];
                            m_run[j] = 0;
                        end
                    end else begin
                        m_run[j] = 0;
                    end
                end
            end
            m_k++;
            m_rise = m_st[0] & ~old[0];
            m_mask = m_st[N_SW:1] ^ old[N_SW:1];
            m_chg  = (m_mask != '0);
            for (int i = SYNC_STAGES - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = {sw_i, btn_i};
        end
    end

    // Per-cycle comparison plus event bookkeeping for directed checks.
    bit              chk_en = 0;
    int              n_rise = 0;
    int              n_chg  = 0;
    int              n_both = 0;
    logic [N_SW-1:0] last_mask = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("btn_o", {31'd0, btn_o}, {31'd0, m_st[0]});
            check_eq("btn_rise_o", {31'd0, btn_rise_o}, {31'd0, m_rise});
            check_eq("sw_o", {16'd0, sw_o}, {16'd0, m_st[N_SW:1]});
            check_eq("sw_chg_o", {31'd0, sw_chg_o}, {31'd0, m_chg});
            check_eq("sw_chg_mask_o", {16'd0, sw_chg_mask_o}, {16'd0, m_mask});
            if (btn_rise_o) n_rise++;
            if (sw_chg_o) begin
                n_chg++;
                last_mask = sw_chg_mask_o;
            end
            if (btn_rise_o && sw_chg_o) n_both++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        cyc(n);
        rst_i = 1'b0;
    endtask

    task automatic clr_events();
        n_rise = 0; n_chg = 0; n_both = 0; last_mask = '0;
    endtask

    initial begin
        rst_i = 1'b1; btn_i = 1'b0; sw_i = '0;
        cyc(3);
        chk_en = 1;
        check_eq("rst_btn_o", {31'd0, btn_o}, 32'd0);
        check_eq("rst_sw_o", {16'd0, sw_o}, 32'd0);
        check_eq("rst_mask", {16'd0, sw_chg_mask_o}, 32'd0);
        rst_i = 1'b0;
        cyc(20);

        // Clean button press and release.
        clr_events();
        btn_i = 1'b1; cyc(20);
        check_eq("press_level", {31'd0, btn_o}, 32'd1);
        check_eq("press_pulses", n_rise, 32'd1);
        clr_events();
        btn_i = 1'b0; cyc(20);
        check_eq("release_level", {31'd0, btn_o}, 32'd0);
        check_eq("release_pulses", n_rise, 32'd0);

        // Bounce: two ticks high then low.
        clr_events();
        btn_i = 1'b1; cyc(2 * SAMPLE_DIV);
        btn_i = 1'b0; cyc(20);
        check_eq("bounce_pulses", n_rise, 32'd0);
        check_eq("bounce_level", {31'd0, btn_o}, 32'd0);

        // Single-cycle glitches at a drifting phase: at most one tick sees each.
        for (int i = 0; i < 12; i++) begin
            btn_i = 1'b1; cyc(1);
            btn_i = 1'b0; cyc(SAMPLE_DIV);
        end
        // Toggling every tick period.
        for (int i = 0; i < 10; i++) begin
            btn_i = ~btn_i; cyc(SAMPLE_DIV);
        end
        btn_i = 1'b0; cyc(20);
        check_eq("glitch_pulses", n_rise, 32'd0);

        // Switch changes and masks.
        clr_events();
        sw_i = 16'h0005; cyc(20);
        check_eq("sw5_level", {16'd0, sw_o}, 32'h0005);
        check_eq("sw5_mask", {16'd0, last_mask}, 32'h0005);
        check_eq("sw5_pulses", n_chg, 32'd1);
        clr_events();
        sw_i = 16'h0004; cyc(20);
        check_eq("sw4_mask", {16'd0, last_mask}, 32'h0001);
        check_eq("sw4_pulses", n_chg, 32'd1);

        // Switches held high through reset are reported once debounced.
        sw_i = 16'hFFFF;
        do_reset(3);
        clr_events();
        cyc(20);
        check_eq("ffff_level", {16'd0, sw_o}, 32'hFFFF);
        check_eq("ffff_mask", {16'd0, last_mask}, 32'hFFFF);

        // Reset mid-count discards the partial count.
        do_reset(2);
        btn_i = 1'b1; cyc(9);
        do_reset(1);
        clr_events();
        cyc(10);
        check_eq("midrst_early", {31'd0, btn_o}, 32'd0);
        cyc(20);
        check_eq("midrst_level", {31'd0, btn_o}, 32'd1);
        check_eq("midrst_pulses", n_rise, 32'd1);

        // Button and switches accepted on the same tick.
        btn_i = 1'b0; sw_i = '0;
        do_reset(2);
        clr_events();
        btn_i = 1'b1; sw_i = 16'h8001; cyc(20);
        check_eq("both_same_cycle", n_both, 32'd1);

        // Randomized segments with occasional resets.
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset($urandom_range(1, 3));
            end
            if ($urandom_range(0, 3) == 0) begin
                btn_i = $urandom_range(0, 1);
            end
            if ($urandom_range(0, 2) == 0) begin
                sw_i = N_SW'($urandom());
            end else if ($urandom_range(0, 1) == 0) begin
                sw_i = sw_i ^ N_SW'(1 << $urandom_range(0, N_SW - 1));
            end
            cyc($urandom_range(1, 20));
        end

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
